// File: rtl/wut_pkg.sv
// Shared types and constants for the multi-channel wake-up timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wut_pkg;

    // Per-channel run state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } wut_state_e;

    // Legal parameter ranges, enforced at elaboration by the top level.
    localparam int NCH_MIN         = 1;
    localparam int NCH_MAX         = 16;
    localparam int WIDTH_MIN       = 2;
    localparam int WIDTH_MAX       = 32;
    localparam int PRESC_WIDTH_MIN = 1;
    localparam int PRESC_WIDTH_MAX = 32;

    // Low bit index of channel ch inside a flattened per-channel bus.
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/wut_channel.sv
// One wake-up timer channel: start handshake, IDLE/RUN FSM, tick counter, sticky flag.
// Latency: ack/busy one cycle after req is sampled; flag on the edge of the expiring tick.
// Backpressure: none; 4-phase req/ack, ack simply follows req by one cycle.
//
// Ports:
//   perm_clk, perm_rstb   always-on clock, async active-low reset
//   tick                  shared prescaler tick (one cycle wide)
//   limit                 expiry count L (0 treated as 1)
//   periodic              1 = reload and keep running on expiry
//   ch_disable            synchronous stop, blocks start
//   start_req / start_ack 4-phase start handshake
//   it_clr / it_flag      sticky expiry flag and its clear (set wins)
//   busy                  channel is in RUN
module wut_channel
    import wut_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             perm_clk,
    input  logic             perm_rstb,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    input  logic             periodic,
    input  logic             ch_disable,
    input  logic             start_req,
    output logic             start_ack,
    input  logic             it_clr,
    output logic             it_flag,
    output logic             busy
);

    wut_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             flag_q, flag_d;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   lim_eff;
    logic             expire;

    always_comb begin
        // One extra bit so counter+1 never wraps before the compare.
        cnt_inc = {1'b0, cnt_q} + (WIDTH+1)'(1);
        lim_eff = (limit == '0) ? (WIDTH+1)'(1) : {1'b0, limit};
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        // ack just mirrors req one cycle later; it is what makes a held
        // req unable to restart the channel.
        ack_d   = start_req;

        case (state_q)
            ST_IDLE: begin
                if (start_req && !ack_q && !ch_disable) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (ch_disable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    // >= so a limit lowered below the count expires on the next tick.
                    if (cnt_inc >= lim_eff) begin
                        expire = 1'b1;
                        cnt_d  = '0;
                        if (!periodic) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        flag_d = expire | (flag_q & ~it_clr);
    end

    always_ff @(posedge perm_clk or negedge perm_rstb) begin
        if (!perm_rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            flag_q  <= flag_d;
        end
    end

    assign start_ack = ack_q;
    assign it_flag   = flag_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: rtl/wut_multi.sv
// Multi-channel always-on wake-up timer: shared prescaler feeding NCH channels, merged irq.
// Latency: flag max(L,1)*(P+1) cycles after ack for a lone channel; trig_it one cycle after flag.
// Backpressure: none; each channel uses a 4-phase start req/ack handshake.
//
// Ports:
//   perm_clk, perm_rstb      always-on clock, async active-low reset
//   perm_wut_prescaler       tick period minus one (P)
//   perm_wut_limit           per-channel limit L, channel i at [i*WIDTH +: WIDTH]
//   perm_wut_periodic        per-channel periodic (1) / one-shot (0)
//   perm_wut_disable         per-channel synchronous stop
//   perm_wut_irq_en          per-channel interrupt enable
//   perm_wut_start_req/_ack  per-channel start handshake
//   perm_wut_it_clr/_flag    per-channel sticky flag and clear
//   perm_wut_busy            per-channel RUN indication
//   perm_wut_trig_it         registered OR of enabled flags
module wut_multi
    import wut_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   perm_clk,
    input  logic                   perm_rstb,
    input  logic [PRESC_WIDTH-1:0] perm_wut_prescaler,
    input  logic [NCH*WIDTH-1:0]   perm_wut_limit,
    input  logic [NCH-1:0]         perm_wut_periodic,
    input  logic [NCH-1:0]         perm_wut_disable,
    input  logic [NCH-1:0]         perm_wut_irq_en,
    input  logic [NCH-1:0]         perm_wut_start_req,
    output logic [NCH-1:0]         perm_wut_start_ack,
    input  logic [NCH-1:0]         perm_wut_it_clr,
    output logic [NCH-1:0]         perm_wut_it_flag,
    output logic [NCH-1:0]         perm_wut_busy,
    output logic                   perm_wut_trig_it
);

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("wut_multi: NCH out of range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("wut_multi: WIDTH out of range");
    end
    if (PRESC_WIDTH < PRESC_WIDTH_MIN || PRESC_WIDTH > PRESC_WIDTH_MAX) begin : g_bad_presc
        $error("wut_multi: PRESC_WIDTH out of range");
    end

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   trig_q, trig_d;
    logic                   any_run;
    logic                   tick;

    assign any_run = |perm_wut_busy;

    always_comb begin
        // >= rather than == so lowering P mid-run ticks at once instead of
        // wrapping through the whole prescaler range.
        tick    = any_run && (presc_q >= perm_wut_prescaler);
        // Held at 0 while idle so the first channel to start sees a full tick period.
        presc_d = (!any_run || tick) ? '0 : presc_q + PRESC_WIDTH'(1);
        trig_d  = |(perm_wut_it_flag & perm_wut_irq_en);
    end

    always_ff @(posedge perm_clk or negedge perm_rstb) begin
        if (!perm_rstb) begin
            presc_q <= '0;
            trig_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            trig_q  <= trig_d;
        end
    end

    assign perm_wut_trig_it = trig_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        wut_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .perm_clk   (perm_clk),
            .perm_rstb  (perm_rstb),
            .tick       (tick),
            .limit      (perm_wut_limit[ch_lo(i, WIDTH) +: WIDTH]),
            .periodic   (perm_wut_periodic[i]),
            .ch_disable (perm_wut_disable[i]),
            .start_req  (perm_wut_start_req[i]),
            .start_ack  (perm_wut_start_ack[i]),
            .it_clr     (perm_wut_it_clr[i]),
            .it_flag    (perm_wut_it_flag[i]),
            .busy       (perm_wut_busy[i])
        );
    end

endmodule

// File: doc/wut_multi.md
Name: wut_multi

Overview:
Multi-channel wake-up timer for the permanent (always-on) digital domain. It is the successor of the single-channel wake-up timer, with these additions:
- NCH independent channels sharing one programmable prescaler.
- Per-channel one-shot or periodic mode.
- Sticky per-channel interrupt flags with clear and enable, merged into one interrupt line to the wake-up controller.
- A clean 4-phase start request/acknowledge handshake per channel.

Parameters:
NCH, 4, number of timer channels (1..16)
WIDTH, 16, counter/limit width per channel (2..32)
PRESC_WIDTH, 8, prescaler width; tick period = prescaler+1 clock cycles

Ports:
perm_clk  input  1  always-on clock
perm_rstb  input  1  asynchronous active-low reset
perm_wut_prescaler  input  PRESC_WIDTH  shared tick divider value P
perm_wut_limit  input  NCH*WIDTH  per-channel limit L, channel i at [i*WIDTH +: WIDTH]
perm_wut_periodic  input  NCH  1 = periodic, 0 = one-shot
perm_wut_disable  input  NCH  synchronous per-channel stop
perm_wut_irq_en  input  NCH  per-channel interrupt enable
perm_wut_start_req  input  NCH  4-phase start request
perm_wut_start_ack  output  NCH  4-phase start acknowledge
perm_wut_it_clr  input  NCH  flag clear, sampled each cycle
perm_wut_it_flag  output  NCH  sticky expiry flags
perm_wut_busy  output  NCH  channel in RUN
perm_wut_trig_it  output  1  registered OR of (flag & irq_en)

Behaviour:
Reset and clock
- Clock is perm_clk. Reset perm_rstb is asynchronous active-low.
- Reset values: all outputs 0, all counters 0, prescaler counter 0, all channels IDLE.

Channel FSM (states IDLE, RUN)
- IDLE -> RUN when req=1, ack=0, disable=0. Counter is loaded with 0. ack and busy rise on the same edge.
- RUN -> IDLE in three cases:
  - disable=1: counter cleared, no flag set.
  - one-shot expiry.
  - reset.
- Periodic expiry: stay in RUN, counter reloads to 0.

Handshake
- ack sets when req=1 and ack=0, one cycle after req is sampled.
- ack stays high while req=1, and clears one cycle after req=0.
- ack is independent of the FSM. A req seen while disabled is still acknowledged, but the channel stays IDLE.
- Consequence: a held-high req never restarts a channel. A restart needs req low, then high again.

Prescaler
- One counter p, held at 0 while no channel is in RUN.
- While any channel is in RUN: tick=1 when p >= P, then p wraps to 0; otherwise p increments.
- Using >= means a mid-run decrease of P yields a tick on the next cycle, never a wrap through 2^PRESC_WIDTH.

Counting and expiry
- On a tick, in RUN: if counter+1 >= max(L,1), the channel expires and the counter goes to 0; otherwise the counter increments.
- L=0 behaves as L=1.
- If L is changed below the current count, expiry occurs on the next tick.
- Widths: compare at WIDTH+1 bits, so counter+1 cannot overflow.

Timing
- Single active channel: expiry flag rises exactly max(L,1)*(P+1) cycles after ack rises.
- Channel starting while others already run: first period lies in [(max(L,1)-1)*(P+1)+1, max(L,1)*(P+1)]. Later periods are exact.

Flags and interrupt
- flag[i] sets on expiry and clears on it_clr[i]. A simultaneous set and clear leaves the flag set.
- Flag is independent of irq_en.
- trig_it = registered |(flag & irq_en), i.e. one cycle after the flag.
- Disable does not clear the flag.

Decomposition:
- Package wut_pkg: channel state enum (IDLE, RUN), per-channel slice-index helper constants, and parameter range limits used by elaboration checks.
- Sub-module wut_channel: per-channel FSM, counter, handshake and flag logic, instanced NCH times with a generate loop.
- The top level holds the prescaler, the any-RUN reduction and trig_it.

Test Plan:
- P=0, L=3, ch0 one-shot, req high at c0 -> ack and busy rise at c1; flag rises at c4; busy falls at c4; trig_it at c5 with irq_en=1; no further flags while req held high.
- P=1, L=2, ch1 periodic -> flag expiries every 4 cycles; it_clr pulsed on an expiry cycle leaves flag=1; it_clr pulsed on another cycle clears it; busy stays 1.
- ch0 running, disable pulsed mid-count -> busy=0 next cycle, counter 0, flag unchanged; with req re-toggled after disable drops, full L*(P+1) period is observed.
- L=0, P=0 one-shot -> flag 1 cycle after ack; L changed from 10 to 2 when count=5 -> expiry on next tick.
- Channels 0..3 started at staggered cycles with P=3 -> each first period within the specified bound and exact thereafter; irq_en=0 on ch2 -> flag2 sets, trig_it unaffected by it.
- perm_rstb asserted mid-run with flags set -> all outputs 0 immediately (asynchronous); after release, req must toggle low then high to restart.
